// File: rtl/snake_game_ctrl.sv
// Snake game controller: owns the snake body, direction, item position and
// score, and steps the snake once every TICK_DIV clocks while running.
//
// state | meaning
// IDLE  | waiting for the first start request
// SPAWN | asking the item generator for an item, waiting for its done pulse
// RUN   | counting clocks until the next snake step
// MOVE  | choose direction, register next head position and wall flag
// CHECK | resolve eat / collision, update body, size and score
// OVER  | game lost, outputs frozen until restart
module snake_game_ctrl #(
  parameter int XSIZE    = 48,
  parameter int YSIZE    = 64,
  parameter int MAX_SIZE = 20,
  parameter int TICK_DIV = 25000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [1:0]            i_Dir,
  input  logic                  i_Dir_Valid,
  input  logic [5:0]            i_Item_x,
  input  logic [5:0]            i_Item_y,
  input  logic                  i_isMakeItem_Done,
  output logic [MAX_SIZE*6-1:0] o_Body_x,
  output logic [MAX_SIZE*6-1:0] o_Body_y,
  output logic [11:0]           o_Body_size,
  output logic                  o_ItemNeed,
  output logic [5:0]            o_Item_x,
  output logic [5:0]            o_Item_y,
  output logic [7:0]            o_Score,
  output logic                  o_GameOver,
  output logic [2:0]            o_State
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [5:0]  X_MAX     = 6'(XSIZE - 1);
  localparam logic [5:0]  Y_MAX     = 6'(YSIZE - 1);
  localparam logic [5:0]  X_MID     = 6'(XSIZE / 2);
  localparam logic [5:0]  Y_MID     = 6'(YSIZE / 2);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [11:0] SIZE_MAX  = 12'(MAX_SIZE);

  logic [2:0]  state, state_next;
  logic [31:0] tick;
  logic [5:0]  body_x [MAX_SIZE];
  logic [5:0]  body_y [MAX_SIZE];
  logic [11:0] size;
  logic [7:0]  score;
  logic [5:0]  item_x, item_y;
  logic [1:0]  dir, dir_pend, dir_sel;
  logic [5:0]  nh_x, nh_y, cand_x, cand_y;
  logic        wall, cand_wall, item_need;
  logic        start_req, eat, self_hit, collide;

  // Start is only honoured while idle or after a lost game
  always_comb start_req = i_Start && ((state == ST_IDLE) || (state == ST_OVER));

  // Pick the step direction (a reversal request keeps the old one) and the candidate head
  always_comb begin
    dir_sel   = (dir_pend == (dir ^ 2'd2)) ? dir : dir_pend;
    cand_x    = body_x[0];
    cand_y    = body_y[0];
    cand_wall = 1'b0;
    case (dir_sel)
      DIR_UP:    begin cand_y = body_y[0] - 6'd1; cand_wall = (body_y[0] == 6'd0);  end
      DIR_RIGHT: begin cand_x = body_x[0] + 6'd1; cand_wall = (body_x[0] == X_MAX); end
      DIR_DOWN:  begin cand_y = body_y[0] + 6'd1; cand_wall = (body_y[0] == Y_MAX); end
      default:   begin cand_x = body_x[0] - 6'd1; cand_wall = (body_x[0] == 6'd0);  end
    endcase
  end

  // Eat and collision; the tail cell only counts as occupied when the snake grows
  always_comb begin
    eat      = (nh_x == item_x) && (nh_y == item_y);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if ((body_x[i] == nh_x) && (body_y[i] == nh_y) &&
          (eat ? (12'(i) < size) : ((12'(i) + 12'd1) < size)))
        self_hit = 1'b1;
    end
    collide = wall || self_hit;
  end

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_Start) state_next = ST_SPAWN;
      ST_SPAWN: if (i_isMakeItem_Done) state_next = ST_RUN;
      ST_RUN:   if (tick == TICK_LAST) state_next = ST_MOVE;
      ST_MOVE:  state_next = ST_CHECK;
      ST_CHECK: begin
        if (collide)  state_next = ST_OVER;
        else if (eat) state_next = ST_SPAWN;
        else          state_next = ST_RUN;
      end
      ST_OVER:  if (i_Start) state_next = ST_SPAWN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Game datapath: tick counter, direction, body, size, score, item
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < MAX_SIZE; i++) begin
        body_x[i] <= 6'd0;
        body_y[i] <= 6'd0;
      end
      size      <= 12'd0;
      score     <= 8'd0;
      item_x    <= 6'd0;
      item_y    <= 6'd0;
      tick      <= 32'd0;
      dir       <= DIR_UP;
      dir_pend  <= DIR_UP;
      nh_x      <= 6'd0;
      nh_y      <= 6'd0;
      wall      <= 1'b0;
      item_need <= 1'b0;
    end else begin
      item_need <= (state_next == ST_SPAWN) && (state != ST_SPAWN);
      if (i_Dir_Valid) dir_pend <= i_Dir;
      if ((state_next == ST_RUN) && (state != ST_RUN)) tick <= 32'd0;
      else if (state == ST_RUN)                        tick <= tick + 32'd1;
      if (start_req) begin
        for (int i = 0; i < MAX_SIZE; i++) begin
          body_x[i] <= (i < 3) ? X_MID : 6'd0;
          body_y[i] <= (i < 3) ? (Y_MID + 6'(i)) : 6'd0;
        end
        size     <= 12'd3;
        score    <= 8'd0;
        dir      <= DIR_UP;
        dir_pend <= DIR_UP;
      end
      if ((state == ST_SPAWN) && i_isMakeItem_Done) begin
        item_x <= i_Item_x;
        item_y <= i_Item_y;
      end
      if (state == ST_MOVE) begin
        dir  <= dir_sel;
        nh_x <= cand_x;
        nh_y <= cand_y;
        wall <= cand_wall;
      end
      if ((state == ST_CHECK) && !collide) begin
        for (int i = MAX_SIZE - 1; i > 0; i--) begin
          body_x[i] <= body_x[i-1];
          body_y[i] <= body_y[i-1];
        end
        body_x[0] <= nh_x;
        body_y[0] <= nh_y;
        if (eat) begin
          if (size < SIZE_MAX) size <= size + 12'd1;
          if (score != 8'hFF)  score <= score + 8'd1;
        end else begin
          // The old tail shifts into slot 'size'; it is no longer part of the snake
          for (int i = 0; i < MAX_SIZE; i++) begin
            if (12'(i) == size) begin
              body_x[i] <= 6'd0;
              body_y[i] <= 6'd0;
            end
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    o_Body_x = '0;
    o_Body_y = '0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      o_Body_x[i*6 +: 6] = body_x[i];
      o_Body_y[i*6 +: 6] = body_y[i];
    end
    o_Body_size = size;
    o_ItemNeed  = item_need;
    o_Item_x    = item_x;
    o_Item_y    = item_y;
    o_Score     = score;
    o_GameOver  = (state == ST_OVER);
    o_State     = state;
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Testbench for snake_game_ctrl with a fast step rate (TICK_DIV=4).
module tb_snake_game_ctrl;

  localparam int MS = 20;
  localparam logic [2:0] S_IDLE = 3'd0, S_SPAWN = 3'd1, S_RUN = 3'd2,
                         S_MOVE = 3'd3, S_CHECK = 3'd4, S_OVER = 3'd5;

  logic            i_Clk = 1'b0;
  logic            i_Rst = 1'b0;
  logic            i_Start = 1'b0;
  logic [1:0]      i_Dir = 2'd0;
  logic            i_Dir_Valid = 1'b0;
  logic [5:0]      i_Item_x = 6'd0, i_Item_y = 6'd0;
  logic            i_isMakeItem_Done = 1'b0;
  logic [MS*6-1:0] o_Body_x, o_Body_y;
  logic [11:0]     o_Body_size;
  logic            o_ItemNeed;
  logic [5:0]      o_Item_x, o_Item_y;
  logic [7:0]      o_Score;
  logic            o_GameOver;
  logic [2:0]      o_State;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0]  hx, hy;
    logic [11:0] size;
    logic [7:0]  score;
    logic [2:0]  st;
  } exp_t;
  exp_t exp_q[$];

  snake_game_ctrl #(.XSIZE(48), .YSIZE(64), .MAX_SIZE(MS), .TICK_DIV(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Dir(i_Dir),
    .i_Dir_Valid(i_Dir_Valid), .i_Item_x(i_Item_x), .i_Item_y(i_Item_y),
    .i_isMakeItem_Done(i_isMakeItem_Done), .o_Body_x(o_Body_x), .o_Body_y(o_Body_y),
    .o_Body_size(o_Body_size), .o_ItemNeed(o_ItemNeed), .o_Item_x(o_Item_x),
    .o_Item_y(o_Item_y), .o_Score(o_Score), .o_GameOver(o_GameOver), .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (o_State !== s && n < budget) begin
      @(negedge i_Clk);
      n++;
    end
    vectors++;
    if (o_State !== s) begin
      miscompares++;
      $display("FAIL wait_state: state %0d after %0d cycles, required %0d", o_State, n, s);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
    end
  endtask

  task automatic step();
    wait_state(S_CHECK, 40);
    @(negedge i_Clk);
  endtask

  task automatic steer(input logic [1:0] d);
    i_Dir = d;
    i_Dir_Valid = 1'b1;
    @(negedge i_Clk);
    i_Dir_Valid = 1'b0;
  endtask

  task automatic give_item(input logic [5:0] ix, input logic [5:0] iy);
    i_Item_x = ix;
    i_Item_y = iy;
    i_isMakeItem_Done = 1'b1;
    @(negedge i_Clk);
    i_isMakeItem_Done = 1'b0;
  endtask

  task automatic start_game(input logic [5:0] ix, input logic [5:0] iy);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    give_item(ix, iy);
  endtask

  task automatic do_reset();
    i_Rst = 1'b0;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
  endtask

  task automatic test_reset();
    @(negedge i_Clk);
    vectors++;
    if ({o_State, o_Body_size, o_Score, o_ItemNeed, o_GameOver, o_Item_x, o_Item_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_scalars: state %0d size %0d score %0d need %b over %b item (%0d,%0d), required all 0",
               o_State, o_Body_size, o_Score, o_ItemNeed, o_GameOver, o_Item_x, o_Item_y);
    end
    vectors++;
    if ({o_Body_x, o_Body_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_body: x %h y %h, required 0", o_Body_x, o_Body_y);
    end
    i_Rst = 1'b1;
    @(negedge i_Clk);
  endtask

  task automatic test_start();
    logic [MS*6-1:0] ebx, eby;
    ebx = '0;
    eby = '0;
    for (int k = 0; k < 3; k++) begin
      ebx[k*6 +: 6] = 6'd24;
      eby[k*6 +: 6] = 6'(32 + k);
    end
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    vectors++;
    if (o_State !== S_SPAWN || o_ItemNeed !== 1'b1) begin
      miscompares++;
      $display("FAIL start_spawn: state %0d need %b, required 1 1", o_State, o_ItemNeed);
    end
    vectors++;
    if (o_Body_x !== ebx || o_Body_y !== eby || o_Body_size !== 12'd3) begin
      miscompares++;
      $display("FAIL start_body: x %h y %h size %0d, required x %h y %h size 3",
               o_Body_x, o_Body_y, o_Body_size, ebx, eby);
    end
    repeat (4) @(negedge i_Clk);
    vectors++;
    if (o_State !== S_SPAWN || o_ItemNeed !== 1'b0) begin
      miscompares++;
      $display("FAIL spawn_wait: state %0d need %b, required 1 0", o_State, o_ItemNeed);
    end
    give_item(6'd10, 6'd10);
    vectors++;
    if (o_State !== S_RUN || o_Item_x !== 6'd10 || o_Item_y !== 6'd10) begin
      miscompares++;
      $display("FAIL start_item: state %0d item (%0d,%0d), required 2 (10,10)", o_State, o_Item_x, o_Item_y);
    end
  endtask

  task automatic test_move();
    int cnt = 0;
    exp_t e;
    while (o_State === S_RUN && cnt < 20) begin
      cnt++;
      @(negedge i_Clk);
    end
    vectors++;
    if (cnt != 4 || o_State !== S_MOVE) begin
      miscompares++;
      $display("FAIL tick_len: %0d RUN cycles then state %0d, required 4 then 3", cnt, o_State);
    end
    exp_q.push_back('{hx: 6'd24, hy: 6'd31, size: 12'd3, score: 8'd0, st: S_RUN});
    @(negedge i_Clk);
    vectors++;
    if (o_State !== S_CHECK) begin
      miscompares++;
      $display("FAIL move_check: state %0d, required 4", o_State);
    end
    @(negedge i_Clk);
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State} !== {e.hx, e.hy, e.size, e.score, e.st}) begin
      miscompares++;
      $display("FAIL move_head: head (%0d,%0d) size %0d score %0d state %0d, required (%0d,%0d) %0d %0d %0d",
               o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, e.hx, e.hy, e.size, e.score, e.st);
    end
    vectors++;
    if (o_Body_x[12 +: 6] !== 6'd24 || o_Body_y[12 +: 6] !== 6'd33 ||
        o_Body_x[18 +: 6] !== 6'd0 || o_Body_y[18 +: 6] !== 6'd0) begin
      miscompares++;
      $display("FAIL move_tail: seg2 (%0d,%0d) seg3 (%0d,%0d), required (24,33) (0,0)",
               o_Body_x[12 +: 6], o_Body_y[12 +: 6], o_Body_x[18 +: 6], o_Body_y[18 +: 6]);
    end
  endtask

  task automatic test_reverse();
    exp_t e;
    steer(2'd2);
    i_Start = 1'b1;
    exp_q.push_back('{hx: 6'd24, hy: 6'd30, size: 12'd3, score: 8'd0, st: S_RUN});
    @(negedge i_Clk);
    i_Start = 1'b0;
    step();
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State} !== {e.hx, e.hy, e.size, e.score, e.st}) begin
      miscompares++;
      $display("FAIL reverse_ignored: head (%0d,%0d) size %0d score %0d state %0d, required (%0d,%0d) %0d %0d %0d",
               o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, e.hx, e.hy, e.size, e.score, e.st);
    end
    steer(2'd1);
    exp_q.push_back('{hx: 6'd25, hy: 6'd30, size: 12'd3, score: 8'd0, st: S_RUN});
    step();
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State} !== {e.hx, e.hy, e.size, e.score, e.st}) begin
      miscompares++;
      $display("FAIL turn_right: head (%0d,%0d) size %0d score %0d state %0d, required (%0d,%0d) %0d %0d %0d",
               o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, e.hx, e.hy, e.size, e.score, e.st);
    end
  endtask

  task automatic test_eat();
    exp_t e;
    int hy = 32, sz = 3, sc = 0;
    do_reset();
    start_game(6'd24, 6'd31);
    for (int n = 0; n < 20; n++) begin
      exp_q.push_back('{hx: 6'd24, hy: 6'(hy - 1), size: 12'((sz < MS) ? sz + 1 : sz),
                        score: 8'(sc + 1), st: S_SPAWN});
      step();
      e = exp_q.pop_front();
      vectors++;
      if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, o_ItemNeed} !==
          {e.hx, e.hy, e.size, e.score, e.st, 1'b1}) begin
        miscompares++;
        $display("FAIL eat_%0d: head (%0d,%0d) size %0d score %0d state %0d need %b, required (%0d,%0d) %0d %0d %0d 1",
                 n, o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, o_ItemNeed,
                 e.hx, e.hy, e.size, e.score, e.st);
      end
      hy = hy - 1;
      sz = (sz < MS) ? sz + 1 : sz;
      sc = sc + 1;
      if (n == 0) begin
        vectors++;
        if (o_Body_y[18 +: 6] !== 6'd34 || o_Body_x[24 +: 6] !== 6'd0 || o_Body_y[24 +: 6] !== 6'd0) begin
          miscompares++;
          $display("FAIL eat_grow_tail: seg3 y %0d seg4 (%0d,%0d), required 34 (0,0)",
                   o_Body_y[18 +: 6], o_Body_x[24 +: 6], o_Body_y[24 +: 6]);
        end
      end
      give_item(6'd24, 6'(hy - 1));
    end
    vectors++;
    if (o_Body_x[(MS-1)*6 +: 6] !== 6'd24 || o_Body_y[(MS-1)*6 +: 6] !== 6'(hy + MS - 1)) begin
      miscompares++;
      $display("FAIL full_tail: seg19 (%0d,%0d), required (24,%0d)",
               o_Body_x[(MS-1)*6 +: 6], o_Body_y[(MS-1)*6 +: 6], hy + MS - 1);
    end
  endtask

  task automatic test_wall();
    exp_t e;
    do_reset();
    start_game(6'd0, 6'd0);
    steer(2'd1);
    exp_q.push_back('{hx: 6'd47, hy: 6'd32, size: 12'd3, score: 8'd0, st: S_RUN});
    for (int s = 0; s < 23; s++) step();
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State} !== {e.hx, e.hy, e.size, e.score, e.st}) begin
      miscompares++;
      $display("FAIL edge_reach: head (%0d,%0d) size %0d score %0d state %0d, required (%0d,%0d) %0d %0d %0d",
               o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, e.hx, e.hy, e.size, e.score, e.st);
    end
    exp_q.push_back('{hx: 6'd47, hy: 6'd32, size: 12'd3, score: 8'd0, st: S_OVER});
    step();
    repeat (5) @(negedge i_Clk);
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, o_GameOver} !==
        {e.hx, e.hy, e.size, e.score, e.st, 1'b1}) begin
      miscompares++;
      $display("FAIL wall_over: head (%0d,%0d) size %0d score %0d state %0d over %b, required (%0d,%0d) %0d %0d %0d 1",
               o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State, o_GameOver,
               e.hx, e.hy, e.size, e.score, e.st);
    end
    vectors++;
    if (o_Body_x[6 +: 6] !== 6'd46 || o_Body_y[6 +: 6] !== 6'd32 ||
        o_Body_x[12 +: 6] !== 6'd45 || o_Body_y[12 +: 6] !== 6'd32) begin
      miscompares++;
      $display("FAIL wall_body: seg1 (%0d,%0d) seg2 (%0d,%0d), required (46,32) (45,32)",
               o_Body_x[6 +: 6], o_Body_y[6 +: 6], o_Body_x[12 +: 6], o_Body_y[12 +: 6]);
    end
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    vectors++;
    if ({o_State, o_ItemNeed, o_GameOver, o_Body_size, o_Score, o_Body_x[5:0], o_Body_y[5:0]} !==
        {S_SPAWN, 1'b1, 1'b0, 12'd3, 8'd0, 6'd24, 6'd32}) begin
      miscompares++;
      $display("FAIL restart: state %0d need %b over %b size %0d score %0d head (%0d,%0d), required 1 1 0 3 0 (24,32)",
               o_State, o_ItemNeed, o_GameOver, o_Body_size, o_Score, o_Body_x[5:0], o_Body_y[5:0]);
    end
  endtask

  // Size-4 snake turns right, down, left onto its own tail cell
  task automatic test_tail_case(input logic [5:0] ix, input logic [5:0] iy, input logic expect_over);
    exp_t e;
    do_reset();
    start_game(6'd24, 6'd31);
    step();
    give_item(ix, iy);
    steer(2'd1);
    step();
    steer(2'd2);
    step();
    steer(2'd3);
    if (expect_over)
      exp_q.push_back('{hx: 6'd25, hy: 6'd32, size: 12'd4, score: 8'd1, st: S_OVER});
    else
      exp_q.push_back('{hx: 6'd24, hy: 6'd32, size: 12'd4, score: 8'd1, st: S_RUN});
    step();
    e = exp_q.pop_front();
    vectors++;
    if ({o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State} !== {e.hx, e.hy, e.size, e.score, e.st}) begin
      miscompares++;
      $display("FAIL tail_case_%0d: head (%0d,%0d) size %0d score %0d state %0d, required (%0d,%0d) %0d %0d %0d",
               expect_over, o_Body_x[5:0], o_Body_y[5:0], o_Body_size, o_Score, o_State,
               e.hx, e.hy, e.size, e.score, e.st);
    end
    vectors++;
    if (o_Body_x[18 +: 6] !== 6'd24 || o_Body_y[18 +: 6] !== (expect_over ? 6'd32 : 6'd31)) begin
      miscompares++;
      $display("FAIL tail_seg3_%0d: seg3 (%0d,%0d), required (24,%0d)",
               expect_over, o_Body_x[18 +: 6], o_Body_y[18 +: 6], expect_over ? 32 : 31);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_game(6'd5, 6'd6);
    wait_state(S_MOVE, 40);
    @(negedge i_Clk);
    vectors++;
    if (o_State !== S_CHECK) begin
      miscompares++;
      $display("FAIL mid_in_check: state %0d, required 4", o_State);
    end
    i_Rst = 1'b0;
    #1;
    vectors++;
    if ({o_State, o_Body_size, o_Score, o_ItemNeed, o_GameOver, o_Item_x, o_Item_y, o_Body_x, o_Body_y} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: state %0d size %0d score %0d item (%0d,%0d) body x %h y %h, required all 0",
               o_State, o_Body_size, o_Score, o_Item_x, o_Item_y, o_Body_x, o_Body_y);
    end
    @(negedge i_Clk);
    i_Rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_move();
    test_reverse();
    test_eat();
    test_wall();
    test_tail_case(6'd0, 6'd0, 1'b0);
    test_tail_case(6'd24, 6'd32, 1'b1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
